// File: rtl/lpc_tpm_cycle_engine.sv
// rtl/lpc_tpm_cycle_engine.sv - LPC master for single-byte TPM I/O cycles
// Optional abort sequence on SYNC timeout: define LPC_ABORT_EN.
module lpc_tpm_cycle_engine #(
  parameter int          SYNC_TIMEOUT = 1024,
  parameter logic [3:0]  START_NIBBLE = 4'b0101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_write,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        done,
  output logic        error,
  output logic [7:0]  rdata,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  input  logic [3:0]  lad_in,
  output logic        lframe_n
);

  localparam int CLOG = $clog2(SYNC_TIMEOUT + 1);
  localparam int CW   = (CLOG < 2) ? 2 : CLOG;

  typedef enum logic [4:0] {
    IDLE, START, CYCTYPE, ADDR0, ADDR1, ADDR2, ADDR3, WDATA0, WDATA1,
    TAR1, TAR2, SYNC, RDATA0, RDATA1, TARP1, TARP2, ABORT, ABORTEND, FINISH
  } state_t;

  state_t        state, nextState;
  logic          isWr;
  logic [15:0]   addrQ;
  logic [7:0]    wdataQ;
  logic          errFlag;
  logic [CW-1:0] cnt;
  logic          syncGo;
  logic          syncTimeout;

  // 0000 and 1010 both let the peripheral finish its data phase
  assign syncGo      = (lad_in == 4'b0000) || (lad_in == 4'b1010);
  assign syncTimeout = (state == SYNC) && !syncGo && (cnt == CW'(SYNC_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (start) nextState = START;
      START:    nextState = CYCTYPE;
      CYCTYPE:  nextState = ADDR0;
      ADDR0:    nextState = ADDR1;
      ADDR1:    nextState = ADDR2;
      ADDR2:    nextState = ADDR3;
      ADDR3:    nextState = isWr ? WDATA0 : TAR1;
      WDATA0:   nextState = WDATA1;
      WDATA1:   nextState = TAR1;
      TAR1:     nextState = TAR2;
      TAR2:     nextState = SYNC;
      SYNC: begin
        if (syncGo)
          nextState = isWr ? TARP1 : RDATA0;
        else if (syncTimeout)
`ifdef LPC_ABORT_EN
          nextState = ABORT;
`else
          nextState = FINISH;
`endif
      end
      RDATA0:   nextState = RDATA1;
      RDATA1:   nextState = TARP1;
      TARP1:    nextState = TARP2;
      TARP2:    nextState = FINISH;
      ABORT:    if (cnt == CW'(3)) nextState = ABORTEND;
      ABORTEND: nextState = FINISH;
      FINISH:   nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    lad_out  = 4'hF;
    lad_oe   = 1'b0;
    lframe_n = 1'b1;
    case (state)
      IDLE:    ready = 1'b1;
      START:   begin lframe_n = 1'b0; lad_oe = 1'b1; lad_out = START_NIBBLE; end
      CYCTYPE: begin lad_oe = 1'b1; lad_out = isWr ? 4'b0010 : 4'b0000; end
      ADDR0:   begin lad_oe = 1'b1; lad_out = addrQ[15:12]; end
      ADDR1:   begin lad_oe = 1'b1; lad_out = addrQ[11:8]; end
      ADDR2:   begin lad_oe = 1'b1; lad_out = addrQ[7:4]; end
      ADDR3:   begin lad_oe = 1'b1; lad_out = addrQ[3:0]; end
      WDATA0:  begin lad_oe = 1'b1; lad_out = wdataQ[3:0]; end
      WDATA1:  begin lad_oe = 1'b1; lad_out = wdataQ[7:4]; end
      TAR1:    lad_oe = 1'b1;
      ABORT:   begin lframe_n = 1'b0; lad_oe = 1'b1; end
      FINISH:  begin done = 1'b1; error = errFlag; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      isWr    <= 1'b0;
      addrQ   <= '0;
      wdataQ  <= '0;
      errFlag <= 1'b0;
      cnt     <= '0;
      rdata   <= '0;
    end else begin
      // cnt measures cycles spent in the current state
      cnt <= (state != nextState) ? '0 : cnt + 1'b1;
      if (state == IDLE && start) begin
        isWr    <= is_write;
        addrQ   <= addr;
        wdataQ  <= wdata;
        errFlag <= 1'b0;
      end
      if (state == SYNC && (lad_in == 4'b1010 || syncTimeout))
        errFlag <= 1'b1;
      if (state == RDATA0 && !errFlag) rdata[3:0] <= lad_in;
      if (state == RDATA1 && !errFlag) rdata[7:4] <= lad_in;
    end
  end

endmodule

// File: tb/tb_lpc_tpm_cycle_engine.sv
// tb/tb_lpc_tpm_cycle_engine.sv - directed bench for lpc_tpm_cycle_engine
// Expected timings assume SYNC_TIMEOUT=8; abort expectations follow LPC_ABORT_EN.
module tb_lpc_tpm_cycle_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_write = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        ready, done, error;
  logic [7:0]  rdata;
  logic [3:0]  lad_out;
  logic        lad_oe;
  logic [3:0]  lad_in = 4'hF;
  logic        lframe_n;

  int tests = 0;
  int fails = 0;

  logic [3:0] lin [0:31];
  logic [3:0] loA [0:31];
  logic       oeA [0:31];
  logic       frA [0:31];
  int         doneAt;
  int         doneCnt;
  logic       errAtDone;
  logic [7:0] rdAtDone;

  lpc_tpm_cycle_engine #(.SYNC_TIMEOUT(8), .START_NIBBLE(4'b0101)) dut (
    .clk(clk), .reset(reset), .start(start), .is_write(is_write),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .error(error),
    .rdata(rdata), .lad_out(lad_out), .lad_oe(lad_oe), .lad_in(lad_in),
    .lframe_n(lframe_n)
  );

  always #5 clk = ~clk;

  task automatic clearLin();
    for (int i = 0; i < 32; i++) lin[i] = 4'hF;
  endtask

  // Offset 0 is the START cycle; lin[k] is what the peripheral drives in cycle k.
  task automatic runBus(input logic w, input logic [15:0] a, input logic [7:0] d, input int busyAt);
    doneAt = -1; doneCnt = 0; errAtDone = 1'b0; rdAtDone = 8'h00;
    is_write = w; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      start  = (k == busyAt);
      lad_in = lin[k];
      loA[k] = lad_out; oeA[k] = lad_oe; frA[k] = lframe_n;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) begin doneAt = k; errAtDone = error; rdAtDone = rdata; end
      end
      @(negedge clk);
    end
    start = 1'b0; lad_in = 4'hF;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'h00);
    chk("reset_lad_out", 32'(lad_out), 32'hF);
    chk("reset_lad_oe", 32'(lad_oe), 32'd0);
    chk("reset_lframe_n", 32'(lframe_n), 32'd1);
  endtask

  task automatic test_write();
    logic [3:0] exp [0:8];
    exp = '{4'h5, 4'h2, 4'h0, 4'h0, 4'h1, 4'h8, 4'h5, 4'hA, 4'hF};
    clearLin(); lin[10] = 4'h0;
    runBus(1'b1, 16'h0018, 8'hA5, -1);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("wr_lad_%0d", k), 32'(loA[k]), 32'(exp[k]));
      chk($sformatf("wr_oe_%0d", k), 32'(oeA[k]), 32'd1);
    end
    chk("wr_oe_tar2", 32'(oeA[9]), 32'd0);
    chk("wr_oe_sync", 32'(oeA[10]), 32'd0);
    chk("wr_lframe_start", 32'(frA[0]), 32'd0);
    chk("wr_lframe_cyctype", 32'(frA[1]), 32'd1);
    chk("wr_done_at", 32'(doneAt), 32'd13);
    chk("wr_error", 32'(errAtDone), 32'd0);
    chk("wr_done_count", 32'(doneCnt), 32'd1);
  endtask

  task automatic test_read_wait();
    clearLin();
    lin[8] = 4'h5; lin[9] = 4'h5; lin[10] = 4'h5; lin[11] = 4'h0;
    lin[12] = 4'hC; lin[13] = 4'h3;
    runBus(1'b0, 16'h0024, 8'h00, -1);
    chk("rd_cyctype", 32'(loA[1]), 32'h0);
    chk("rd_addr2", 32'(loA[4]), 32'h2);
    chk("rd_addr3", 32'(loA[5]), 32'h4);
    chk("rd_tar1", 32'(oeA[6]), 32'd1);
    chk("rd_tar2", 32'(oeA[7]), 32'd0);
    chk("rd_oe_rdata", 32'(oeA[12]), 32'd0);
    chk("rd_done_at", 32'(doneAt), 32'd16);
    chk("rd_rdata", 32'(rdAtDone), 32'h3C);
    chk("rd_error", 32'(errAtDone), 32'd0);
  endtask

  task automatic test_sync_error();
    clearLin();
    lin[8] = 4'hA; lin[9] = 4'h7; lin[10] = 4'h7;
    runBus(1'b0, 16'h0030, 8'h00, -1);
    chk("serr_done_at", 32'(doneAt), 32'd13);
    chk("serr_error", 32'(errAtDone), 32'd1);
    chk("serr_rdata_kept", 32'(rdAtDone), 32'h3C);
  endtask

  task automatic test_timeout();
    clearLin();
    for (int k = 8; k < 32; k++) lin[k] = 4'h6;
    runBus(1'b0, 16'h0040, 8'h00, -1);
    chk("to_error", 32'(errAtDone), 32'd1);
    chk("to_done_count", 32'(doneCnt), 32'd1);
    chk("to_rdata_kept", 32'(rdAtDone), 32'h3C);
`ifdef LPC_ABORT_EN
    chk("to_done_at", 32'(doneAt), 32'd21);
    for (int k = 16; k < 20; k++) begin
      chk($sformatf("to_abort_lframe_%0d", k), 32'(frA[k]), 32'd0);
      chk($sformatf("to_abort_lad_%0d", k), 32'(loA[k]), 32'hF);
      chk($sformatf("to_abort_oe_%0d", k), 32'(oeA[k]), 32'd1);
    end
    chk("to_abortend_lframe", 32'(frA[20]), 32'd1);
    chk("to_abortend_oe", 32'(oeA[20]), 32'd0);
`else
    chk("to_done_at", 32'(doneAt), 32'd16);
    chk("to_finish_lframe", 32'(frA[16]), 32'd1);
    chk("to_finish_oe", 32'(oeA[16]), 32'd0);
`endif
  endtask

  task automatic test_reset_mid();
    int seenDone;
    seenDone = 0;
    is_write = 1'b1; addr = 16'hBEEF; wdata = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      if (done) seenDone++;
      @(negedge clk);
    end
    chk("rst_mid_in_addr2", 32'(lad_out), 32'hE);
    reset = 1'b1;
    @(negedge clk);
    if (done) seenDone++;
    reset = 1'b0;
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_oe", 32'(lad_oe), 32'd0);
    chk("rst_mid_lframe", 32'(lframe_n), 32'd1);
    repeat (4) begin
      if (done) seenDone++;
      @(negedge clk);
    end
    chk("rst_mid_no_done", 32'(seenDone), 32'd0);
    clearLin(); lin[8] = 4'h0; lin[9] = 4'hA; lin[10] = 4'h5;
    runBus(1'b0, 16'h0018, 8'h00, -1);
    chk("rst_mid_after_done_at", 32'(doneAt), 32'd13);
    chk("rst_mid_after_rdata", 32'(rdAtDone), 32'h5A);
    chk("rst_mid_after_error", 32'(errAtDone), 32'd0);
  endtask

  task automatic test_busy_start();
    logic [3:0] exp [0:7];
    int extraFrames;
    exp = '{4'h5, 4'h2, 4'h1, 4'h2, 4'h3, 4'h4, 4'hE, 4'h7};
    extraFrames = 0;
    clearLin(); lin[10] = 4'h5; lin[11] = 4'h5; lin[12] = 4'h0;
    runBus(1'b1, 16'h1234, 8'h7E, 10);
    for (int k = 0; k < 8; k++)
      chk($sformatf("busy_lad_%0d", k), 32'(loA[k]), 32'(exp[k]));
    for (int k = 1; k < 32; k++) if (!frA[k]) extraFrames++;
    chk("busy_done_at", 32'(doneAt), 32'd15);
    chk("busy_done_count", 32'(doneCnt), 32'd1);
    chk("busy_no_new_cycle", 32'(extraFrames), 32'd0);
    chk("busy_error", 32'(errAtDone), 32'd0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_sync_error();
    test_timeout();
    test_reset_mid();
    test_busy_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
